// File: rtl/pulse_link_pkg.sv
// Shared definitions for the single-bit pulse-count link (transmit and receive sides).
package pulse_link_pkg;

  // Transmitter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default widths, shared with the receive-side two-bit pulse counter.
  localparam int CNT_W_DEF = 2;
  localparam int GAP_W_DEF = 2;

endpackage

// File: rtl/pulse_gap_timer.sv
// Loadable down-counter timing the idle cycles between pulses.
// last_o is high while the counter holds 1, i.e. during the final gap cycle.
module pulse_gap_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, otherwise count down while enabled, holding at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_train_tx.sv
// Transmit side of the pulse-count link: emits `count` one-cycle pulses on x,
// separated by `gap` idle cycles, then a one-cycle done strobe.
// Optional macro PULSE_TRAIN_TX_OVF_EN adds a sticky ovf output that sets when
// the sent-pulse mirror counter wraps to zero.
module pulse_train_tx
  import pulse_link_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             busy,
  output logic             x,
  output logic             done,
  output logic [CNT_W-1:0] out
`ifdef PULSE_TRAIN_TX_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;   // pulses still owed after the current one
  logic [GAP_W-1:0] gcfg_q;
  logic             x_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] out_q;
  logic             gap_load;
  logic             gap_last;
  logic             fire;

  // A pulse is launched on every edge that enters PULSE.
  always_comb begin
    fire = 1'b0;
    unique case (state_q)
      IDLE:    fire = start && (count != '0);
      PULSE:   fire = (rem_q != '0) && (gcfg_q == '0);
      GAP:     fire = gap_last;
      DONE:    fire = 1'b0;
      default: fire = 1'b0;
    endcase
  end

  assign gap_load = (state_q == PULSE) && (rem_q != '0) && (gcfg_q != '0);

  pulse_gap_timer #(
    .W(GAP_W)
  ) u_gap_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (gap_load),
    .load_val_i (gcfg_q),
    .en_i       (state_q == GAP),
    .last_o     (gap_last)
  );

  // Train sequencer with registered x/busy/done and the sent-pulse mirror counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gcfg_q  <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      x_q    <= fire;
      done_q <= 1'b0;
      if (fire) begin
        out_q <= out_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            gcfg_q <= gap;
            busy_q <= 1'b1;
            if (count != '0) begin
              rem_q   <= count - CNT_W'(1);
              state_q <= PULSE;
            end else begin
              rem_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        PULSE: begin
          if (rem_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (gcfg_q == '0) begin
            rem_q   <= rem_q - CNT_W'(1);
            state_q <= PULSE;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_last) begin
            rem_q   <= rem_q - CNT_W'(1);
            state_q <= PULSE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PULSE_TRAIN_TX_OVF_EN
  logic ovf_q;

  // Sticky flag set by the pulse that wraps the mirror counter to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (fire && (out_q == '1)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

  assign x    = x_q;
  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
